// File: rtl/axistream_pattern_source_if.sv
// Command and AXI-stream bus of the pattern source.
// The master side belongs to the pattern source and the slave side to its upstream/downstream user.
interface axistream_pattern_source_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] cmd_seed;
    logic                  dest_tvalid;
    logic                  dest_tready;
    logic [DATA_WIDTH-1:0] dest_tdata;
    logic                  dest_tlast;

    modport master (
        input  cmd_valid, cmd_len, cmd_seed, dest_tready,
        output cmd_ready, dest_tvalid, dest_tdata, dest_tlast
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_seed, dest_tready,
        input  cmd_ready, dest_tvalid, dest_tdata, dest_tlast
    );
endinterface

// File: rtl/axistream_pattern_source.sv
// AXI-stream traffic source: each accepted command (len, seed) becomes one packet of
// incrementing data words, with tlast on the final beat and a done pulse afterwards.
module axistream_pattern_source #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axistream_pattern_source_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic w_send;
    logic w_last;
    logic w_beat;

    assign w_send = (r_state == SEND);
    assign w_last = (r_remaining == LEN_WIDTH'(1));
    assign w_beat = w_send && bus.dest_tready;

    // Control, data and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A zero-length command is consumed here without producing a packet
                    if (bus.cmd_valid && (bus.cmd_len != '0)) begin
                        r_data      <= bus.cmd_seed;
                        r_remaining <= bus.cmd_len;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    if (w_beat) begin
                        r_data      <= r_data + DATA_WIDTH'(1);
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state     <= IDLE;
                            r_done      <= 1'b1;
                            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake outputs come from registers only; rst masks them in its own cycle
    assign bus.cmd_ready   = !rst && !w_send;
    assign bus.dest_tvalid = !rst && w_send;
    assign bus.dest_tdata  = r_data;
    assign bus.dest_tlast  = !rst && w_send && w_last;

    assign busy      = w_send;
    assign done      = r_done;
    assign pkt_count = r_pkt_count;
endmodule

// File: tb/tb_axistream_pattern_source.sv
// Directed bench for axistream_pattern_source: packet shapes, stalls, wrap,
// zero-length commands, back-to-back commands and mid-packet reset.
module tb_axistream_pattern_source;
    logic        clk;
    logic        rst;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;

    int total;
    int bad;
    int exp_cnt;

    axistream_pattern_source_if #(.DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

    axistream_pattern_source #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (8),
        .CNT_WIDTH (16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .pkt_count(pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE and check every beat against seed+index
    task automatic send_pkt(input logic [7:0] seed, input logic [7:0] len, input bit rnd);
        int          beats;
        int          cyc;
        logic [7:0]  d;
        logic        ready;
        beats = 0;
        cyc   = 0;
        check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_seed  = seed;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
        while (beats < int'(len) && cyc < 200) begin
            d = seed + 8'(beats);
            check_eq("tvalid", 32'(bus.dest_tvalid), 32'd1);
            check_eq("tdata", 32'(bus.dest_tdata), 32'(d));
            check_eq("tlast", 32'(bus.dest_tlast), 32'(beats == int'(len) - 1));
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dest_tready = ready;
            tick();
            if (ready) beats++;
            cyc++;
        end
        check_eq("beats_done", 32'(beats), 32'(len));
        exp_cnt++;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("tvalid_after", 32'(bus.dest_tvalid), 32'd0);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("pkt_count", 32'(pkt_count), 32'(exp_cnt));
        bus.dest_tready = 1'b1;
        tick();
        check_eq("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        exp_cnt         = 0;
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_len     = 8'd0;
        bus.cmd_seed    = 8'd0;
        bus.dest_tready = 1'b1;

        // Reset state and rst gating
        tick();
        tick();
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("rst_tvalid", 32'(bus.dest_tvalid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();

        // 1: plain packet, always ready
        send_pkt(8'h10, 8'd4, 1'b0);
        // 2: random backpressure
        send_pkt(8'h00, 8'd6, 1'b1);
        // 3: data wraps
        send_pkt(8'hFE, 8'd4, 1'b0);
        // 4: single beat, then zero length
        send_pkt(8'hA5, 8'd1, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_seed  = 8'h77;
        bus.cmd_len   = 8'd0;
        check_eq("len0_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check_eq("len0_tvalid", 32'(bus.dest_tvalid), 32'd0);
        check_eq("len0_busy", 32'(busy), 32'd0);
        tick();
        check_eq("len0_done", 32'(done), 32'd0);
        check_eq("len0_tvalid2", 32'(bus.dest_tvalid), 32'd0);
        check_eq("len0_pkt_count", 32'(pkt_count), 32'(exp_cnt));

        // 5: second command held during first packet; one-cycle gap
        bus.cmd_valid = 1'b1;
        bus.cmd_seed  = 8'h20;
        bus.cmd_len   = 8'd3;
        tick();
        bus.cmd_seed = 8'h30;
        bus.cmd_len  = 8'd2;
        for (int i = 0; i < 3; i++) begin
            check_eq("held_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_eq("held_tdata", 32'(bus.dest_tdata), 32'(8'h20 + i));
            check_eq("held_tlast", 32'(bus.dest_tlast), 32'(i == 2));
            tick();
        end
        exp_cnt++;
        check_eq("gap_tvalid", 32'(bus.dest_tvalid), 32'd0);
        check_eq("gap_done", 32'(done), 32'd1);
        check_eq("gap_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("second_tvalid", 32'(bus.dest_tvalid), 32'd1);
            check_eq("second_tdata", 32'(bus.dest_tdata), 32'(8'h30 + i));
            check_eq("second_tlast", 32'(bus.dest_tlast), 32'(i == 1));
            tick();
        end
        exp_cnt++;
        check_eq("second_done", 32'(done), 32'd1);
        check_eq("second_pkt_count", 32'(pkt_count), 32'(exp_cnt));
        tick();

        // 6: reset at beat 2 of an 8-beat packet
        bus.cmd_valid = 1'b1;
        bus.cmd_seed  = 8'h50;
        bus.cmd_len   = 8'd8;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_tdata", 32'(bus.dest_tdata), 32'h52);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_tvalid", 32'(bus.dest_tvalid), 32'd0);
        check_eq("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("mid_rst_tlast", 32'(bus.dest_tlast), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        check_eq("post_rst_tvalid", 32'(bus.dest_tvalid), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_done", 32'(done), 32'd0);
        check_eq("post_rst_pkt_count", 32'(pkt_count), 32'd0);
        check_eq("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        check_eq("post_rst_done2", 32'(done), 32'd0);
        send_pkt(8'h40, 8'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
